// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared types and defaults for the MEM-stage access controller.
//   state_t          : access sequencer state (IDLE / ADDR / DATA)
//   *_DEF localparams: default widths and watchdog limit
package mem_ctrl_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int ADDR_W_DEF      = 32;
  localparam int REG_W_DEF       = 5;
  localparam int TIMEOUT_CYC_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
// Data-memory port bundle between the MEM-stage controller and memory.
//   mem_req/mem_we/mem_addr/mem_wdata : controller -> memory
//   mem_gnt/mem_rvalid/mem_rdata      : memory -> controller
// Modports: master (controller side), slave (memory side).
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_ctrl_watchdog.sv
// mem_ctrl_watchdog
// Outstanding-access watchdog, used only when MEM_ACCESS_CTRL_TIMEOUT_EN is set.
//   clk, rst     : clock, async active-high reset
//   busy         : sequencer is outside IDLE
//   complete     : access finished normally this cycle
//   timeout      : force completion this cycle (combinational)
//   timeout_err  : sticky flag, cleared only by rst
// Down-counter reloaded while idle; it fires on the TIMEOUT_CYC-th busy
// cycle, so with the request cycle in IDLE the stall lasts TIMEOUT_CYC cycles.
import mem_ctrl_pkg::*;

module mem_ctrl_watchdog #(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic complete,
  output logic timeout,
  output logic timeout_err
);
  localparam int              CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  assign timeout = busy & ~complete & (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= LOAD;
      timeout_err <= 1'b0;
    end else begin
      if (!busy || complete) cnt <= LOAD;
      else if (cnt != '0)    cnt <= cnt - CNT_W'(1);
      if (timeout) timeout_err <= 1'b1;
    end
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// MEM-stage sequencer: drives the data-memory req/gnt/rvalid handshake,
// stalls upstream pipeline registers while an access is outstanding and
// owns the MEM/WB register (bubble inserted while stalled).
// Ports:
//   clk, rst              : clock, async active-high reset
//   ex_*                  : EX/MEM register contents
//   mem                   : memory port (mem_access_ctrl_if.master)
//   stall                 : hold PC, IF/ID, ID/EX, EX/MEM
//   wb_*                  : MEM/WB register outputs
//   timeout_err           : sticky watchdog flag
// Optional feature: define MEM_ACCESS_CTRL_TIMEOUT_EN to enable the watchdog.
//
// state | meaning
// IDLE  | no access outstanding; request issued combinationally
// ADDR  | request pending, waiting for gnt
// DATA  | load granted, waiting for rvalid
import mem_ctrl_pkg::*;

module mem_access_ctrl #(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int REG_W       = REG_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic              ex_memto_reg,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [REG_W-1:0]  ex_dst,
  mem_access_ctrl_if.master mem,
  output logic              stall,
  output logic              wb_reg_write,
  output logic              wb_memto_reg,
  output logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] wb_rdata,
  output logic [REG_W-1:0]  wb_dst,
  output logic              timeout_err
);
  if (TIMEOUT_CYC < 1) begin : g_param_check
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t state, state_nxt;
  logic   mem_op, store_done, load_done, complete, timeout, advance;

  assign mem_op        = ex_valid & (ex_mem_read | ex_mem_write);
  // Request is forced low during reset so a dropped access is not re-issued.
  assign mem.mem_req   = mem_op & (state != DATA) & ~rst;
  assign mem.mem_we    = ex_mem_write;
  assign mem.mem_addr  = ADDR_W'(ex_result);
  assign mem.mem_wdata = ex_wdata;

  assign store_done = mem.mem_req & mem.mem_gnt & ex_mem_write;
  assign load_done  = (state == DATA) & mem.mem_rvalid;
  assign complete   = store_done | load_done;
  assign stall      = mem_op & ~complete & ~timeout & ~rst;
  // A timed-out access releases the pipeline but writes back nothing.
  assign advance    = ~stall & ~timeout;

`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
  mem_ctrl_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk         (clk),
    .rst         (rst),
    .busy        (state != IDLE),
    .complete    (complete),
    .timeout     (timeout),
    .timeout_err (timeout_err)
  );
`else
  assign timeout     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ADDR: begin
        if (mem.mem_req && mem.mem_gnt)
          state_nxt = ex_mem_read ? DATA : IDLE;
        else if (mem.mem_req)
          state_nxt = ADDR;
      end
      DATA:    if (mem.mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_reg_write <= 1'b0;
      wb_memto_reg <= 1'b0;
      wb_result    <= '0;
      wb_rdata     <= '0;
      wb_dst       <= '0;
    end else if (advance) begin
      wb_reg_write <= ex_valid & ex_reg_write;
      wb_memto_reg <= ex_memto_reg;
      wb_result    <= ex_result;
      wb_dst       <= ex_dst;
      if (load_done) wb_rdata <= mem.mem_rdata;
    end else begin
      wb_reg_write <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int REG_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_memto_reg;
  logic [DATA_W-1:0] ex_result, ex_wdata;
  logic [REG_W-1:0]  ex_dst;
  logic              stall, wb_reg_write, wb_memto_reg, timeout_err;
  logic [DATA_W-1:0] wb_result, wb_rdata;
  logic [REG_W-1:0]  wb_dst;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  mem_access_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .TIMEOUT_CYC(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_reg_write (ex_reg_write),
    .ex_memto_reg (ex_memto_reg),
    .ex_result    (ex_result),
    .ex_wdata     (ex_wdata),
    .ex_dst       (ex_dst),
    .mem          (mem_bus),
    .stall        (stall),
    .wb_reg_write (wb_reg_write),
    .wb_memto_reg (wb_memto_reg),
    .wb_result    (wb_result),
    .wb_rdata     (wb_rdata),
    .wb_dst       (wb_dst),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic rd, input logic wr, input logic rw,
                          input logic m2r, input logic [DATA_W-1:0] res,
                          input logic [DATA_W-1:0] wd, input logic [REG_W-1:0] dst);
    ex_valid = v; ex_mem_read = rd; ex_mem_write = wr; ex_reg_write = rw;
    ex_memto_reg = m2r; ex_result = res; ex_wdata = wd; ex_dst = dst;
  endtask

  task automatic drive_mem(input logic gnt, input logic rv, input logic [DATA_W-1:0] rd);
    mem_bus.mem_gnt = gnt; mem_bus.mem_rvalid = rv; mem_bus.mem_rdata = rd;
  endtask

  task automatic go_idle;
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive_mem(1'b0, 1'b0, '0);
  endtask

  // Reset asserted with a load presented: outputs forced quiet.
  task automatic test_reset;
    rst = 1'b1;
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h200, '0, 5'd1);
    drive_mem(1'b1, 1'b1, 32'hFFFF_FFFF);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_checks++; if (mem_bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mem_bus.mem_req); end
    tick;
    n_checks++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_wb_reg_write: got %b want 0", wb_reg_write); end
    n_checks++; if (wb_result !== 32'h0) begin n_fail++; $display("FAIL reset_wb_result: got %h want 0", wb_result); end
    n_checks++; if (wb_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_wb_rdata: got %h want 0", wb_rdata); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    go_idle;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_alu;
    drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_00AA, '0, 5'd5);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b want 0", stall); end
    n_checks++; if (mem_bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL alu_req: got %b want 0", mem_bus.mem_req); end
    tick;
    n_checks++; if (wb_result !== 32'hAA) begin n_fail++; $display("FAIL alu_wb_result: got %h want aa", wb_result); end
    n_checks++; if (wb_dst !== 5'd5) begin n_fail++; $display("FAIL alu_wb_dst: got %0d want 5", wb_dst); end
    n_checks++; if (wb_reg_write !== 1'b1) begin n_fail++; $display("FAIL alu_wb_reg_write: got %b want 1", wb_reg_write); end
    go_idle;
    tick;
    n_checks++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL bubble_wb_reg_write: got %b want 0", wb_reg_write); end
  endtask

  task automatic test_store;
    drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h1234_5678, 5'd0);
    drive_mem(1'b1, 1'b0, '0);
    #1;
    n_checks++; if (mem_bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL store_req: got %b want 1", mem_bus.mem_req); end
    n_checks++; if (mem_bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL store_we: got %b want 1", mem_bus.mem_we); end
    n_checks++; if (mem_bus.mem_addr !== 32'h100) begin n_fail++; $display("FAIL store_addr: got %h want 100", mem_bus.mem_addr); end
    n_checks++; if (mem_bus.mem_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL store_wdata: got %h want 12345678", mem_bus.mem_wdata); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL store_stall: got %b want 0", stall); end
    tick;
    n_checks++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL store_wb_reg_write: got %b want 0", wb_reg_write); end
    n_checks++; if (wb_result !== 32'h100) begin n_fail++; $display("FAIL store_wb_result: got %h want 100", wb_result); end
    go_idle;
  endtask

  // gnt 2 cycles after request, rvalid 3 cycles after gnt: 5 stall cycles.
  task automatic test_load;
    drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h11, '0, 5'd3);
    tick;
    n_checks++; if (wb_reg_write !== 1'b1) begin n_fail++; $display("FAIL load_pre_wb_reg_write: got %b want 1", wb_reg_write); end
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h200, '0, 5'd7);
    for (int i = 0; i < 6; i++) begin
      drive_mem(i == 2, i == 5, (i == 5) ? 32'hDEAD_BEEF : 32'h5555_0000 + i);
      #1;
      n_checks++; if (stall !== (i < 5)) begin n_fail++; $display("FAIL load_stall[%0d]: got %b want %b", i, stall, i < 5); end
      n_checks++; if (mem_bus.mem_req !== (i <= 2)) begin n_fail++; $display("FAIL load_req[%0d]: got %b want %b", i, mem_bus.mem_req, i <= 2); end
      tick;
      if (i < 5) begin
        n_checks++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL load_bubble[%0d]: got %b want 0", i, wb_reg_write); end
      end
    end
    n_checks++; if (wb_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_wb_rdata: got %h want deadbeef", wb_rdata); end
    n_checks++; if (wb_memto_reg !== 1'b1) begin n_fail++; $display("FAIL load_wb_memto_reg: got %b want 1", wb_memto_reg); end
    n_checks++; if (wb_reg_write !== 1'b1) begin n_fail++; $display("FAIL load_wb_reg_write: got %b want 1", wb_reg_write); end
    n_checks++; if (wb_dst !== 5'd7) begin n_fail++; $display("FAIL load_wb_dst: got %0d want 7", wb_dst); end
    n_checks++; if (wb_result !== 32'h200) begin n_fail++; $display("FAIL load_wb_result: got %h want 200", wb_result); end
    go_idle;
  endtask

  task automatic test_spurious;
    drive_mem(1'b1, 1'b1, 32'h0BAD_F00D);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL spur_stall: got %b want 0", stall); end
    n_checks++; if (mem_bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL spur_req: got %b want 0", mem_bus.mem_req); end
    tick;
    n_checks++; if (wb_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL spur_wb_rdata: got %h want deadbeef", wb_rdata); end
    // ALU op alongside stray rvalid must not capture rdata either.
    drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h77, '0, 5'd2);
    tick;
    n_checks++; if (wb_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL spur_alu_wb_rdata: got %h want deadbeef", wb_rdata); end
    // State must still be IDLE: a fresh load without gnt requests and stalls.
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h300, '0, 5'd9);
    drive_mem(1'b0, 1'b0, '0);
    #1;
    n_checks++; if (mem_bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL spur_next_req: got %b want 1", mem_bus.mem_req); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL spur_next_stall: got %b want 1", stall); end
    tick;
    drive_mem(1'b1, 1'b0, '0);
    tick;
    drive_mem(1'b0, 1'b1, 32'h1357_9BDF);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL spur_next_done_stall: got %b want 0", stall); end
    tick;
    n_checks++; if (wb_rdata !== 32'h1357_9BDF) begin n_fail++; $display("FAIL spur_next_wb_rdata: got %h want 13579bdf", wb_rdata); end
    go_idle;
  endtask

  task automatic test_back_to_back;
    drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h400, 32'hA5A5_A5A5, 5'd0);
    drive_mem(1'b1, 1'b0, '0);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_store_stall: got %b want 0", stall); end
    tick;
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h404, '0, 5'd10);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_load_stall: got %b want 1", stall); end
    n_checks++; if (mem_bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL b2b_load_we: got %b want 0", mem_bus.mem_we); end
    tick;
    n_checks++; if (wb_result !== 32'h400) begin n_fail++; $display("FAIL b2b_hold_wb_result: got %h want 400", wb_result); end
    drive_mem(1'b0, 1'b1, 32'hCAFE_F00D);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_rvalid_stall: got %b want 0", stall); end
    n_checks++; if (mem_bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_data_req: got %b want 0", mem_bus.mem_req); end
    tick;
    n_checks++; if (wb_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL b2b_wb_rdata: got %h want cafef00d", wb_rdata); end
    n_checks++; if (wb_result !== 32'h404) begin n_fail++; $display("FAIL b2b_wb_result: got %h want 404", wb_result); end
    n_checks++; if (wb_reg_write !== 1'b1) begin n_fail++; $display("FAIL b2b_wb_reg_write: got %b want 1", wb_reg_write); end
    drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h55, '0, 5'd11);
    drive_mem(1'b0, 1'b0, '0);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_alu_stall: got %b want 0", stall); end
    tick;
    n_checks++; if (wb_result !== 32'h55) begin n_fail++; $display("FAIL b2b_alu_wb_result: got %h want 55", wb_result); end
    n_checks++; if (wb_memto_reg !== 1'b0) begin n_fail++; $display("FAIL b2b_alu_wb_memto: got %b want 0", wb_memto_reg); end
    n_checks++; if (wb_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL b2b_alu_wb_rdata: got %h want cafef00d", wb_rdata); end
    // Store with one wait cycle before gnt.
    drive_ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h500, 32'h1, 5'd12);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_wstore_stall: got %b want 1", stall); end
    tick;
    n_checks++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL b2b_wstore_bubble: got %b want 0", wb_reg_write); end
    drive_mem(1'b1, 1'b0, '0);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_wstore_gnt_stall: got %b want 0", stall); end
    tick;
    n_checks++; if (wb_reg_write !== 1'b1) begin n_fail++; $display("FAIL b2b_wstore_wb_reg_write: got %b want 1", wb_reg_write); end
    go_idle;
    tick;
  endtask

  task automatic test_reset_mid_access;
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h600, '0, 5'd13);
    drive_mem(1'b1, 1'b0, '0);
    tick;
    drive_mem(1'b0, 1'b0, '0);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rstmid_data_stall: got %b want 1", stall); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b want 0", stall); end
    n_checks++; if (mem_bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req: got %b want 0", mem_bus.mem_req); end
    n_checks++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL rstmid_wb_reg_write: got %b want 0", wb_reg_write); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_timeout_err: got %b want 0", timeout_err); end
    tick;
    rst = 1'b0;
    #1;
    // Back in IDLE: the still-presented load is requested again.
    n_checks++; if (mem_bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle_req: got %b want 1", mem_bus.mem_req); end
    go_idle;
    tick;
    n_checks++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_wb: got %b want 0", wb_reg_write); end
  endtask

  task automatic test_timeout;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h700, '0, 5'd14);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (stall !== (i < 4)) begin n_fail++; $display("FAIL to_stall[%0d]: got %b want %b", i, stall, i < 4); end
      tick;
    end
    go_idle;
    #1;
    n_checks++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL to_wb_reg_write: got %b want 0", wb_reg_write); end
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_err_set: got %b want 1", timeout_err); end
    repeat (3) tick;
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %b want 1", timeout_err); end
`else
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h700, '0, 5'd14);
    repeat (20) tick;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL nto_stall: got %b want 1", stall); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL nto_err: got %b want 0", timeout_err); end
    go_idle;
`endif
    rst = 1'b1;
    #1;
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_err_clear: got %b want 0", timeout_err); end
    tick;
    rst = 1'b0;
    tick;
  endtask

  initial begin
    go_idle;
    test_reset;
    test_alu;
    test_store;
    test_load;
    test_spurious;
    test_back_to_back;
    test_reset_mid_access;
    test_timeout;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
